// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write/read responder.
// Holds the FSM state enum, ACK/NACK line levels and frame size.
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_DATA,
    S_DATA_ACK,
    S_IGNORE,
    S_RD_DATA,
    S_RD_ACK
  } state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // address byte plus two data bytes
  localparam int FRAME_BYTES = 3;
  localparam logic [1:0] DATA_BYTES = 2'(FRAME_BYTES - 1);

endpackage

// File: rtl/i2c_edge_sync.sv
// Input synchronizer plus rise/fall detector for one bus line.
// Ports: clk, din (async line) -> level, rise, fall (clk domain).
module i2c_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  // No reset: the chain keeps tracking the bus during reset so that
  // leaving reset never shows a phantom edge on a line held low.
  always_ff @(posedge clk) begin
    sync <= {sync[SYNC_STAGES-2:0], din};
    prev <= sync[SYNC_STAGES-1];
  end

  assign level = sync[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/i2c_responder.sv
// I2C responder: captures {addr_rw, byte1, byte2} write frames.
// Ports: clk, reset (sync, high), i2c_sclk, i2c_sdat (open drain),
//   i2c_data (last frame), data_valid (pulse), busy.
// Optional: I2C_RESPONDER_READ_EN adds a 2-byte read of i2c_data[15:0].
module i2c_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i2c_sclk,
  inout  wire         i2c_sdat,
  output logic [23:0] i2c_data,
  output logic        data_valid,
  output logic        busy
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
    .clk  (clk),
    .din  (i2c_sclk),
    .level(scl),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  i2c_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
    .clk  (clk),
    .din  (i2c_sdat),
    .level(sda),
    .rise (sda_rise),
    .fall (sda_fall)
  );

  state_t      state;
  logic [2:0]  bitcnt;
  logic [1:0]  nbytes;
  logic        phase;
  logic [6:0]  shreg;
  logic [23:0] frame;
  logic        sda_low;
`ifdef I2C_RESPONDER_READ_EN
  logic [7:0]  rd_shift;
`endif

  logic       start, stop;
  logic [7:0] byte_in;

  assign start   = sda_fall & scl;
  assign stop    = sda_rise & scl;
  assign byte_in = {shreg, sda};

  assign i2c_sdat = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      bitcnt     <= '0;
      nbytes     <= '0;
      phase      <= 1'b0;
      shreg      <= '0;
      frame      <= '0;
      sda_low    <= 1'b0;
      i2c_data   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
`ifdef I2C_RESPONDER_READ_EN
      rd_shift   <= '0;
`endif
    end else begin
      data_valid <= 1'b0;
      if (start) begin
        state   <= S_ADDR;
        bitcnt  <= '0;
        nbytes  <= '0;
        phase   <= 1'b0;
        sda_low <= 1'b0;
        busy    <= 1'b1;
      end else if (stop) begin
        if (state == S_DATA && nbytes == DATA_BYTES) begin
          i2c_data   <= frame;
          data_valid <= 1'b1;
        end
        state   <= S_IDLE;
        phase   <= 1'b0;
        sda_low <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          S_ADDR: if (scl_rise) begin
            shreg  <= byte_in[6:0];
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              if (byte_in[7:1] == DEV_ADDR && !byte_in[0]) begin
                state <= S_ADDR_ACK;
                frame <= {frame[15:0], byte_in};
`ifdef I2C_RESPONDER_READ_EN
              end else if (byte_in[7:1] == DEV_ADDR) begin
                state <= S_ADDR_ACK;
`endif
              end else begin
                state <= S_IGNORE;
                busy  <= 1'b0;
              end
            end
          end
          // first falling edge pulls the line, the next one releases
          S_ADDR_ACK, S_DATA_ACK: if (scl_fall) begin
            if (!phase) begin
              phase   <= 1'b1;
              sda_low <= 1'b1;
            end else begin
              phase   <= 1'b0;
              sda_low <= 1'b0;
              state   <= S_DATA;
`ifdef I2C_RESPONDER_READ_EN
              if (state == S_ADDR_ACK && shreg[0]) begin
                state    <= S_RD_DATA;
                nbytes   <= '0;
                sda_low  <= ~i2c_data[15];
                rd_shift <= {i2c_data[14:8], 1'b0};
              end
`endif
            end
          end
          S_DATA: if (scl_rise) begin
            shreg  <= byte_in[6:0];
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              if (nbytes < DATA_BYTES) begin
                nbytes <= nbytes + 2'd1;
                frame  <= {frame[15:0], byte_in};
                state  <= S_DATA_ACK;
              end else begin
                state <= S_IGNORE;
                busy  <= 1'b0;
              end
            end
          end
`ifdef I2C_RESPONDER_READ_EN
          // bitcnt wraps to 0 after the 8th rising edge of a byte
          S_RD_DATA: begin
            if (scl_rise) begin
              bitcnt <= bitcnt + 3'd1;
            end else if (scl_fall) begin
              if (bitcnt == 3'd0) begin
                sda_low <= 1'b0;
                state   <= S_RD_ACK;
              end else begin
                sda_low  <= ~rd_shift[7];
                rd_shift <= {rd_shift[6:0], 1'b0};
              end
            end
          end
          S_RD_ACK: begin
            if (scl_rise) begin
              if (sda == I2C_NACK || nbytes != 2'd0) begin
                state <= S_IGNORE;
                busy  <= 1'b0;
              end else begin
                phase <= 1'b1;
              end
            end else if (scl_fall && phase) begin
              phase    <= 1'b0;
              nbytes   <= 2'd1;
              state    <= S_RD_DATA;
              sda_low  <= ~i2c_data[7];
              rd_shift <= {i2c_data[6:0], 1'b0};
            end
          end
`endif
          S_IDLE, S_IGNORE: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_responder.sv
// Self-checking bench for i2c_responder: bit-level I2C initiator,
// scoreboard queues for responder bits and captured frames.
module tb_i2c_responder;

  localparam logic [6:0] DEV = 7'h1D;
  localparam int Q = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl = 1'b1;
  logic drv_low = 1'b0;
  wire  sdat;
  logic [23:0] i2c_data;
  logic data_valid;
  logic busy;

  assign sdat = drv_low ? 1'b0 : 1'bz;
  pullup (sdat);

  always #5 clk = ~clk;

  i2c_responder #(.DEV_ADDR(DEV), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .i2c_sclk  (scl),
    .i2c_sdat  (sdat),
    .i2c_data  (i2c_data),
    .data_valid(data_valid),
    .busy      (busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int dut_low_cnt = 0;
  logic        exp_bits[$];
  logic [23:0] exp_frames[$];
  logic        chk_slot = 1'b0;
  logic [23:0] last_data = '0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // responder pulling the line while the initiator releases it
  always @(posedge clk)
    if (sdat === 1'b0 && !drv_low) dut_low_cnt++;

  // bit monitor: responder-driven bits sampled at scl high
  initial forever begin
    @(posedge scl);
    #1;
    if (chk_slot) begin
      if (exp_bits.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL resp_bit: unexpected slot, got %b", sdat);
      end else begin
        check("resp_bit", 32'(sdat), 32'(exp_bits.pop_front()));
      end
    end
  end

  // frame monitor: every data_valid pulse consumes one expectation
  initial forever begin
    @(negedge clk);
    if (data_valid) begin
      if (exp_frames.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL frame: unexpected pulse, got %h", i2c_data);
      end else begin
        check("frame", 32'(i2c_data), 32'(exp_frames.pop_front()));
      end
    end
  end

  task automatic wq(input int n = 1);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic i2c_start;
    drv_low = 1'b1; wq();
    scl = 1'b0; wq();
  endtask

  task automatic i2c_stop;
    drv_low = 1'b1; wq();
    scl = 1'b1; wq();
    drv_low = 1'b0; wq(2);
  endtask

  task automatic send_bit(input logic b);
    drv_low = !b; wq();
    scl = 1'b1; wq(2);
    scl = 1'b0; wq();
  endtask

  task automatic resp_bit(input logic e);
    exp_bits.push_back(e);
    drv_low = 1'b0;
    chk_slot = 1'b1; wq();
    scl = 1'b1; wq(2);
    scl = 1'b0;
    chk_slot = 1'b0; wq();
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  function automatic logic addr_ok(input logic [7:0] a);
`ifdef I2C_RESPONDER_READ_EN
    return a[7:1] == DEV;
`else
    return a[7:1] == DEV && !a[0];
`endif
  endfunction

  // d holds data bytes top-aligned: d[23:16] first
  task automatic xfer(input logic [7:0] a, input int nb,
                      input logic [23:0] d);
    logic ok;
    ok = addr_ok(a);
    i2c_start;
    send_byte(a);
    resp_bit(!ok);
    check("busy_after_addr", 32'(busy), 32'(ok));
    for (int i = 0; i < nb; i++) begin
      send_byte(d[23 - 8*i -: 8]);
      resp_bit(!(ok && i < 2));
    end
    if (ok && nb == 2) begin
      last_data = {a, d[23:8]};
      exp_frames.push_back(last_data);
    end
    i2c_stop;
  endtask

`ifdef I2C_RESPONDER_READ_EN
  task automatic rd_xfer;
    logic [7:0] b;
    i2c_start;
    send_byte({DEV, 1'b1});
    resp_bit(1'b0);
    for (int j = 0; j < 2; j++) begin
      b = (j == 0) ? last_data[15:8] : last_data[7:0];
      for (int i = 7; i >= 0; i--) resp_bit(b[i]);
      send_bit(j != 0);
    end
    check("busy_rd_nack", 32'(busy), 32'd0);
    i2c_stop;
  endtask
`endif

  initial begin
    logic [7:0]  a, b;
    logic [23:0] d;
    int r, nb, c0;

    reset = 1'b1; wq(2);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_data", 32'(i2c_data), 32'd0);
    check("rst_sdat", 32'(sdat), 32'd1);
    reset = 1'b0; wq();

    xfer(8'h3a, 2, 24'h42f200);
    wq();
    check("busy_idle", 32'(busy), 32'd0);
`ifdef I2C_RESPONDER_READ_EN
    rd_xfer;
`endif

    c0 = dut_low_cnt;
    xfer(8'h3c, 2, 24'h42f200);
    check("mismatch_sdat_low", 32'(dut_low_cnt - c0), 32'd0);
    check("mismatch_data", 32'(i2c_data), 32'(last_data));

    xfer(8'h3a, 1, 24'h420000);
    xfer(8'h3a, 3, 24'h112233);
    check("overrun_data", 32'(i2c_data), 32'(last_data));

    // reset in the middle of the second byte
    b = 8'h42;
    i2c_start;
    send_byte(8'h3a);
    resp_bit(1'b0);
    for (int i = 7; i >= 4; i--) send_bit(b[i]);
    drv_low = !b[3]; wq();
    scl = 1'b1; wq();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_data", 32'(i2c_data), 32'd0);
    reset = 1'b0;
    last_data = '0;
    scl = 1'b0; wq();
    drv_low = 1'b0; wq();
    scl = 1'b1; wq();
    check("postrst_sdat", 32'(sdat), 32'd1);
    check("postrst_busy", 32'(busy), 32'd0);
    xfer(8'h3a, 2, 24'h42f200);

    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 9);
      if (r < 6) a = {DEV, 1'b0};
      else if (r < 8) a = {7'($urandom), 1'b0};
`ifdef I2C_RESPONDER_READ_EN
      else a = {DEV, 1'b0};
`else
      else a = {DEV, 1'b1};
`endif
      nb = $urandom_range(0, 3);
      d = 24'($urandom);
      xfer(a, nb, d);
      check("rand_data", 32'(i2c_data), 32'(last_data));
    end

    wq(4);
    check("frames_pending", 32'(exp_frames.size()), 32'd0);
    check("bits_pending", 32'(exp_bits.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: run did not complete");
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

endmodule
